// File: rtl/arm_pipe_pkg.sv
// Shared types and defaults for the ARM-style pipeline front end.
package arm_pipe_pkg;

    localparam int          DEF_ADDR_W   = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] INSTR_NOP    = 32'h0000_0000;

    typedef struct packed {
        logic [31:0]           instr;
        logic [DEF_ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of fetched {instr, pc} entries; QDEPTH must be a power of two >= 2.
module fetch_queue
    import arm_pipe_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(QDEPTH):0]  count
);

    localparam int          PW    = $clog2(QDEPTH);
    localparam logic [PW:0] DEPTH = (PW+1)'(QDEPTH);

    fetch_entry_t  mem [QDEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && !flush && (cnt != '0);
    assign do_push = push && !flush && ((cnt != DEPTH) || do_pop);

    // Power-of-two depth lets the pointers wrap modulo QDEPTH on natural overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (PW+1)'(1);
                2'b01:   cnt <= cnt - (PW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // NOTE: entry storage carries no reset; pointers and count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign empty = (cnt == '0);
    assign full  = (cnt == DEPTH);
    assign count = cnt;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, request credits, redirect drop accounting, prefetch queue to IF/ID.
// Optional FETCH_PERF_CNT_EN adds saturating stall/redirect/drop counters. ADDR_W up to 32.
module fetch_unit
    import arm_pipe_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
    parameter int                QDEPTH   = 2
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              if_valid,
    input  logic              id_ready,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc_plus_4
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_redirect_cnt,
    output logic [31:0]       perf_drop_cnt
`endif
);

    localparam int                CW      = $clog2(QDEPTH);
    localparam logic [CW+1:0]     CREDITS = (CW+2)'(QDEPTH);
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(4);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] rsp_pc;
    logic [ADDR_W-1:0] target;
    logic [CW:0]       outstanding;
    logic [CW:0]       drop_cnt;
    logic [CW:0]       q_count;
    logic              q_full;
    logic              q_empty;
    logic              accept;
    logic              rsp_ok;
    logic              push;
    logic              pop;
    logic              discard;
    logic              unused_target_bits;
    fetch_entry_t      q_head;
    fetch_entry_t      push_entry;
    fetch_entry_t      last_entry;
    fetch_entry_t      shown;

    assign target             = {branch_target[ADDR_W-1:2], 2'b00};
    assign unused_target_bits = ^branch_target[1:0];

    // Responses with nothing outstanding are protocol errors and are ignored entirely.
    assign rsp_ok  = imem_rsp_valid && (outstanding != '0);
    assign push    = rsp_ok && !branch_valid && (drop_cnt == '0);
    assign discard = rsp_ok && !push;

    assign imem_req_valid = reset && !branch_valid &&
                            (({1'b0, outstanding} + {1'b0, q_count}) < CREDITS);
    assign imem_req_addr  = fetch_pc;
    assign accept         = imem_req_valid && imem_req_ready;

    assign if_valid = !q_empty && !branch_valid;
    assign pop      = if_valid && id_ready;

    assign push_entry = '{instr: imem_rsp_data, pc: DEF_ADDR_W'(rsp_pc)};

    fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (branch_valid),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    // An empty queue keeps presenting the last instruction handed to IF/ID.
    assign shown        = q_empty ? last_entry : q_head;
    assign if_instr     = shown.instr;
    assign if_pc        = ADDR_W'(shown.pc);
    assign if_pc_plus_4 = if_pc + STEP;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            last_entry  <= '{instr: INSTR_NOP, pc: DEF_ADDR_W'(RESET_PC)};
        end else begin
            outstanding <= outstanding + (CW+1)'(accept) - (CW+1)'(rsp_ok);
            if (branch_valid) begin
                fetch_pc <= target;
                rsp_pc   <= target;
                // outstanding already includes requests still marked for dropping, so
                // everything left in flight after this cycle's response is stale.
                drop_cnt <= outstanding - (CW+1)'(rsp_ok);
            end else begin
                if (accept) fetch_pc <= fetch_pc + STEP;
                if (push)   rsp_pc   <= rsp_pc + STEP;
                if (rsp_ok && (drop_cnt != '0)) drop_cnt <= drop_cnt - (CW+1)'(1);
            end
            if (pop) last_entry <= q_head;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_cnt    <= '0;
            perf_redirect_cnt <= '0;
            perf_drop_cnt     <= '0;
        end else begin
            if (if_valid && !id_ready && (perf_stall_cnt != '1))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (branch_valid && (perf_redirect_cnt != '1))
                perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
            if (discard && (perf_drop_cnt != '1))
                perf_drop_cnt <= perf_drop_cnt + 32'd1;
        end
    end
`endif

    rsp_credit_a: assert property (@(posedge clk) disable iff (!reset)
        imem_rsp_valid |-> (outstanding != '0));
    no_overflow_a: assert property (@(posedge clk) disable iff (!reset)
        push |-> (!q_full || pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall, redirects, reset mid-burst, PC wrap.
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid, req_ready, rsp_valid, branch_valid, if_valid, id_ready;
    logic [31:0] req_addr, rsp_data, branch_target, if_instr, if_pc, if_pc_plus_4;

    logic        w_req_valid, w_req_ready, w_rsp_valid, w_branch_valid, w_if_valid, w_id_ready;
    logic [31:0] w_req_addr, w_rsp_data, w_branch_target, w_if_instr, w_if_pc, w_if_pc_plus_4;

    int          checks = 0;
    int          errors = 0;
    logic        mem_hold;
    logic [31:0] pq [$];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] p_stall, p_redir, p_drop, wp_stall, wp_redir, wp_drop;
`endif

    fetch_unit #(.QDEPTH(4)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (req_valid),
        .imem_req_ready (req_ready),
        .imem_req_addr  (req_addr),
        .imem_rsp_valid (rsp_valid),
        .imem_rsp_data  (rsp_data),
        .branch_valid   (branch_valid),
        .branch_target  (branch_target),
        .if_valid       (if_valid),
        .id_ready       (id_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus_4   (if_pc_plus_4)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_stall_cnt    (p_stall),
        .perf_redirect_cnt (p_redir),
        .perf_drop_cnt     (p_drop)
`endif
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (w_req_valid),
        .imem_req_ready (w_req_ready),
        .imem_req_addr  (w_req_addr),
        .imem_rsp_valid (w_rsp_valid),
        .imem_rsp_data  (w_rsp_data),
        .branch_valid   (w_branch_valid),
        .branch_target  (w_branch_target),
        .if_valid       (w_if_valid),
        .id_ready       (w_id_ready),
        .if_instr       (w_if_instr),
        .if_pc          (w_if_pc),
        .if_pc_plus_4   (w_if_pc_plus_4)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_stall_cnt    (wp_stall),
        .perf_redirect_cnt (wp_redir),
        .perf_drop_cnt     (wp_drop)
`endif
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h1300_0093;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of the main DUT with an in-order memory answering one cycle after acceptance.
    task automatic step;
        logic        acc;
        logic [31:0] a;
        @(negedge clk);
        acc = req_valid && req_ready;
        a   = req_addr;
        @(posedge clk);
        #1;
        if (acc) pq.push_back(a);
        if (!mem_hold && pq.size() != 0) begin
            rsp_valid = 1'b1;
            rsp_data  = instr_of(pq.pop_front());
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = '0;
        end
        #1;
    endtask

    task automatic expect_head(input string tag, input logic [31:0] pc);
        for (int i = 0; i < 16 && !if_valid; i++) step;
        chk({tag, "_valid"}, {31'b0, if_valid}, 32'd1);
        chk({tag, "_pc"}, if_pc, pc);
        chk({tag, "_instr"}, if_instr, instr_of(pc));
    endtask

    task automatic advance_head(input string tag, input logic [31:0] pc);
        step;
        expect_head(tag, pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
        branch_valid = 1'b0; branch_target = '0; id_ready = 1'b0; mem_hold = 1'b0;
        w_req_ready = 1'b0; w_rsp_valid = 1'b0; w_rsp_data = '0;
        w_branch_valid = 1'b0; w_branch_target = '0; w_id_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_valid", {31'b0, req_valid}, 32'd0);
        chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_pc_plus_4", if_pc_plus_4, 32'h4);
        chk("rst_w_req_valid", {31'b0, w_req_valid}, 32'd0);
        chk("rst_w_if_pc", w_if_pc, 32'hFFFF_FFFC);

        // Streaming with a one-cycle memory
        req_ready = 1'b1; id_ready = 1'b1; reset = 1'b1;
        #1;
        chk("first_req_valid", {31'b0, req_valid}, 32'd1);
        chk("first_req_addr", req_addr, 32'h0);
        step;
        chk("fill_if_valid", {31'b0, if_valid}, 32'd0);
        chk("fill_req_addr", req_addr, 32'h4);
        for (int n = 2; n <= 5; n++) begin
            step;
            chk("stream_if_valid", {31'b0, if_valid}, 32'd1);
            chk("stream_if_pc", if_pc, 32'(4 * (n - 2)));
            chk("stream_if_pc_plus_4", if_pc_plus_4, 32'(4 * (n - 2) + 4));
            chk("stream_if_instr", if_instr, instr_of(32'(4 * (n - 2))));
            chk("stream_req_valid", {31'b0, req_valid}, 32'd1);
            chk("stream_req_addr", req_addr, 32'(4 * n));
        end

        // Stall for five cycles, then resume
        id_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            step;
            chk("stall_if_valid", {31'b0, if_valid}, 32'd1);
            chk("stall_if_pc", if_pc, 32'hC);
            chk("stall_if_instr", if_instr, instr_of(32'hC));
        end
        chk("stall_req_valid", {31'b0, req_valid}, 32'd0);
        id_ready = 1'b1;
        for (int m = 1; m <= 5; m++) begin
            step;
            chk("resume_if_pc", if_pc, 32'(12 + 4 * m));
            chk("resume_if_instr", if_instr, instr_of(32'(12 + 4 * m)));
        end

        // Reset mid-burst while a response is on the bus
        reset = 1'b0;
        #1;
        chk("midrst_req_valid", {31'b0, req_valid}, 32'd0);
        chk("midrst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("midrst_if_instr", if_instr, 32'h0);
        chk("midrst_if_pc", if_pc, 32'h0);
        chk("midrst_if_pc_plus_4", if_pc_plus_4, 32'h4);
        step;
        pq.delete();
        rsp_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("restart_req_addr", req_addr, 32'h0);
        step;
        chk("restart_fill_if_valid", {31'b0, if_valid}, 32'd0);
        step;
        chk("restart_if_valid", {31'b0, if_valid}, 32'd1);
        chk("restart_if_pc", if_pc, 32'h0);
        chk("restart_if_instr", if_instr, instr_of(32'h0));

        // Redirect with two requests in flight
        mem_hold = 1'b1;
        step;
        step;
        chk("inflight_if_valid", {31'b0, if_valid}, 32'd0);
        chk("inflight_req_addr", req_addr, 32'h10);
        branch_valid = 1'b1; branch_target = 32'h40;
        #1;
        chk("redir_req_valid", {31'b0, req_valid}, 32'd0);
        chk("redir_if_valid", {31'b0, if_valid}, 32'd0);
        step;
        branch_valid = 1'b0; mem_hold = 1'b0;
        #1;
        chk("redir_next_req_valid", {31'b0, req_valid}, 32'd1);
        chk("redir_next_req_addr", req_addr, 32'h40);
        expect_head("redir_head", 32'h40);
        advance_head("redir_head2", 32'h44);
        advance_head("redir_head3", 32'h48);

        // Redirect in the same cycle as a response and a would-be pop
        branch_valid = 1'b1; branch_target = 32'h80;
        #1;
        chk("same_if_valid", {31'b0, if_valid}, 32'd0);
        chk("same_req_valid", {31'b0, req_valid}, 32'd0);
        step;
        branch_valid = 1'b0;
        #1;
        expect_head("same_head", 32'h80);
        advance_head("same_head2", 32'h84);

        // Back-to-back redirects: the last target wins
        mem_hold = 1'b1;
        step;
        step;
        branch_valid = 1'b1; branch_target = 32'h100;
        step;
        branch_target = 32'h200;
        step;
        branch_valid = 1'b0; mem_hold = 1'b0;
        #1;
        expect_head("b2b_head", 32'h200);
        advance_head("b2b_head2", 32'h204);

        // PC wrap and target alignment on the second instance
        id_ready = 1'b0;
        chk("wrap_req_valid", {31'b0, w_req_valid}, 32'd1);
        chk("wrap_req_addr", w_req_addr, 32'hFFFF_FFFC);
        chk("wrap_if_pc_plus_4", w_if_pc_plus_4, 32'h0);
        w_req_ready = 1'b1;
        step;
        w_req_ready = 1'b0;
        #1;
        chk("wrap_next_req_addr", w_req_addr, 32'h0);
        w_rsp_valid = 1'b1; w_rsp_data = 32'hDEAD_BEEF;
        step;
        w_rsp_valid = 1'b0;
        #1;
        chk("wrap_if_valid", {31'b0, w_if_valid}, 32'd1);
        chk("wrap_if_pc", w_if_pc, 32'hFFFF_FFFC);
        chk("wrap_if_head_pc_plus_4", w_if_pc_plus_4, 32'h0);
        chk("wrap_if_instr", w_if_instr, 32'hDEAD_BEEF);
        w_branch_valid = 1'b1; w_branch_target = 32'h43;
        #1;
        chk("wrap_redir_req_valid", {31'b0, w_req_valid}, 32'd0);
        step;
        w_branch_valid = 1'b0;
        #1;
        chk("wrap_aligned_req_valid", {31'b0, w_req_valid}, 32'd1);
        chk("wrap_aligned_req_addr", w_req_addr, 32'h40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
